fsk_encode: RTL

FSK modulator for the 125 kHz RFID tag path. It takes a parallel frame and serialises it MSB first. Each bit is sent as a square wave derived from the carrier: a 0 bit uses period DIV0 carrier cycles and a 1 bit uses period DIV1. Each bit lasts BIT_CYCLES carrier cycles. It is the transmit counterpart of freq_decode, which classifies 8- and 10-cycle periods, and is used for tag emulation and loopback test of the reader chain.

---
 rtl/fsk_encode.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fsk_encode.sv
// FSK modulator: serialises a latched frame MSB first, each bit a square wave
// whose period (DIV0 or DIV1 carrier ticks) depends on the bit value.
module fsk_encode #(
    parameter int FRAME_BITS = 96,
    parameter int DIV0       = 8,
    parameter int DIV1       = 10,
    parameter int BIT_CYCLES = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sq_wv,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic                  load,
    input  logic                  repeat_frame,
    output logic                  fsk_out,
    output logic                  bit_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  state_dbg
);

    localparam int DIV_MAX = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int CYC_W   = $clog2(BIT_CYCLES);
    localparam int SUB_W   = $clog2(DIV_MAX);
    localparam int IDX_W   = $clog2(FRAME_BITS);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
    localparam logic [SUB_W-1:0] P0_LAST  = SUB_W'(DIV0 - 1);
    localparam logic [SUB_W-1:0] P1_LAST  = SUB_W'(DIV1 - 1);
    localparam logic [SUB_W-1:0] P0_HALF  = SUB_W'(DIV0 / 2);
    localparam logic [SUB_W-1:0] P1_HALF  = SUB_W'(DIV1 / 2);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t state;
    state_t state_next;

    logic [1:0]            sync_q;
    logic                  edge_q;
    logic                  tick;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [FRAME_BITS-1:0] shreg;
    logic [CYC_W-1:0]      cyc;
    logic [SUB_W-1:0]      sub;
    logic [IDX_W-1:0]      bit_idx;

    logic                  last_cyc;
    logic                  last_bit;
    logic                  frame_end;
    logic [SUB_W-1:0]      period_last;
    logic [SUB_W-1:0]      period_half;

    // Carrier tick: 2-flop synchroniser, edge detect, registered pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sq_wv};
            edge_q <= sync_q[1];
            tick   <= sync_q[1] & ~edge_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load) state_next = SEND;
            SEND: if (frame_end && !repeat_frame) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == SEND);
        state_dbg   = (state == SEND);
        bit_out     = shreg[FRAME_BITS-1];
        last_cyc    = (cyc == CYC_LAST);
        last_bit    = (bit_idx == IDX_LAST);
        frame_end   = (state == SEND) && tick && last_cyc && last_bit;
        period_last = bit_out ? P1_LAST : P0_LAST;
        period_half = bit_out ? P1_HALF : P0_HALF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsk_out    <= 1'b0;
            frame_done <= 1'b0;
            frame_reg  <= '0;
            shreg      <= '0;
            cyc        <= '0;
            sub        <= '0;
            bit_idx    <= '0;
        end else begin
            frame_done <= frame_end;
            case (state)
                IDLE: begin
                    fsk_out <= 1'b0;
                    if (load) begin
                        frame_reg <= frame_in;
                        shreg     <= frame_in;
                        cyc       <= '0;
                        sub       <= '0;
                        bit_idx   <= '0;
                    end
                end
                SEND: begin
                    if (tick) begin
                        fsk_out <= (sub < period_half);
                        if (last_cyc) begin
                            // Phase restarts at every bit; the trailing partial period stays as generated.
                            cyc <= '0;
                            sub <= '0;
                            if (last_bit) begin
                                bit_idx <= '0;
                                shreg   <= repeat_frame ? frame_reg : (shreg << 1);
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shreg   <= shreg << 1;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                            sub <= (sub == period_last) ? '0 : sub + 1'b1;
                        end
                    end
                end
                default: fsk_out <= 1'b0;
            endcase
        end
    end

endmodule
